// File: rtl/ad9252_pkg.sv
// rtl/ad9252_pkg.sv - shared state encoding and constants for AD9252 FCO frame alignment
package ad9252_pkg;

    localparam int AD9252_WORD_W = 14;
    localparam logic [AD9252_WORD_W-1:0] AD9252_FCO_PATTERN = 14'h3F80;

    typedef enum logic [2:0] {
        SETTLE = 3'd0,
        CHECK  = 3'd1,
        SLIP   = 3'd2,
        LOCKED = 3'd3,
        FAIL   = 3'd4
    } fco_state_t;

endpackage

// File: rtl/ad9252_fco_align.sv
// rtl/ad9252_fco_align.sv - AD9252 FCO bitslip frame aligner with lock-loss re-alignment
// Optional IDELAY tap stepping after exhausted slips: AD9252_FCO_ALIGN_IDELAY_EN
module ad9252_fco_align
    import ad9252_pkg::*;
#(
    parameter logic [AD9252_WORD_W-1:0] FCO_PATTERN   = AD9252_FCO_PATTERN,
    parameter int                       MATCH_COUNT   = 8,
    parameter int                       SETTLE_CYCLES = 4,
    parameter int                       MAX_SLIPS     = 14,
    parameter int                       LOSS_THRESH   = 4
) (
    input  logic                     ad_dco_fc,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic                     align_start,
    input  logic [AD9252_WORD_W-1:0] fco_pattern,
    output logic                     bit_slip,
    output logic                     aligned,
    output logic                     align_fail,
    output logic                     lock_lost,
    output logic [3:0]               slip_cnt
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
    ,
    output logic                     delay_ce,
    output logic                     delay_inc,
    output logic [4:0]               tap_cnt
`endif
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] LOSS_LAST   = 8'(LOSS_THRESH - 1);
    localparam logic [4:0] SLIP_LIMIT  = 5'(MAX_SLIPS);

    fco_state_t state, state_nxt;
    logic [7:0] settle_cnt, settle_nxt;
    logic [7:0] match_cnt, match_nxt;
    logic [7:0] miss_cnt, miss_nxt;
    logic [3:0] slip_nxt;
    logic       lock_lost_nxt;
    logic       word_match;
    logic       slip_room;
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
    logic [4:0] tap_nxt;
    logic       ce_nxt;
`endif

    assign word_match = (fco_pattern == FCO_PATTERN);
    assign slip_room  = ({1'b0, slip_cnt} < SLIP_LIMIT);

    always_comb begin
        state_nxt     = state;
        settle_nxt    = settle_cnt;
        match_nxt     = match_cnt;
        miss_nxt      = miss_cnt;
        slip_nxt      = slip_cnt;
        lock_lost_nxt = lock_lost;
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
        tap_nxt       = tap_cnt;
        ce_nxt        = 1'b0;
`endif
        if (align_start) begin
            state_nxt     = SETTLE;
            settle_nxt    = '0;
            match_nxt     = '0;
            miss_nxt      = '0;
            slip_nxt      = '0;
            lock_lost_nxt = 1'b0;
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
            tap_nxt       = '0;
`endif
        end else begin
            case (state)
                SETTLE: begin
                    if (settle_cnt >= SETTLE_LAST) begin
                        settle_nxt = '0;
                        state_nxt  = CHECK;
                    end else begin
                        settle_nxt = settle_cnt + 8'd1;
                    end
                end
                CHECK: begin
                    if (word_match) begin
                        if (match_cnt >= MATCH_LAST) begin
                            state_nxt = LOCKED;
                            miss_nxt  = '0;
                        end else begin
                            match_nxt = match_cnt + 8'd1;
                        end
                    end else begin
                        match_nxt = '0;
                        if (slip_room) begin
                            state_nxt = SLIP;
                        end else begin
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
                            // Every slip phase tried at this tap: step the delay line and start over.
                            ce_nxt    = 1'b1;
                            tap_nxt   = tap_cnt + 5'd1;
                            slip_nxt  = '0;
                            state_nxt = (tap_cnt == 5'd31) ? FAIL : SETTLE;
`else
                            state_nxt = FAIL;
`endif
                        end
                    end
                end
                SLIP: begin
                    slip_nxt  = (slip_cnt == 4'hF) ? slip_cnt : slip_cnt + 4'd1;
                    state_nxt = SETTLE;
                end
                LOCKED: begin
                    if (word_match) begin
                        miss_nxt = '0;
                    end else if (miss_cnt >= LOSS_LAST) begin
                        lock_lost_nxt = 1'b1;
                        slip_nxt      = '0;
                        match_nxt     = '0;
                        miss_nxt      = '0;
                        state_nxt     = SETTLE;
                    end else begin
                        miss_nxt = miss_cnt + 8'd1;
                    end
                end
                FAIL:    state_nxt = FAIL;
                default: state_nxt = SETTLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge ad_dco_fc or posedge reset) begin
        if (reset) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            slip_cnt   <= '0;
            lock_lost  <= 1'b0;
            bit_slip   <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
            tap_cnt    <= '0;
            delay_ce   <= 1'b0;
            delay_inc  <= 1'b0;
`endif
        end else if (clk_en) begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            match_cnt  <= match_nxt;
            miss_cnt   <= miss_nxt;
            slip_cnt   <= slip_nxt;
            lock_lost  <= lock_lost_nxt;
            bit_slip   <= (state_nxt == SLIP);
            aligned    <= (state_nxt == LOCKED);
            align_fail <= (state_nxt == FAIL);
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
            tap_cnt    <= tap_nxt;
            delay_ce   <= ce_nxt;
            delay_inc  <= ce_nxt;
`endif
        end else begin
            bit_slip   <= 1'b0;
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
            delay_ce   <= 1'b0;
            delay_inc  <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ad9252_fco_align.sv
// tb/tb_ad9252_fco_align.sv - scoreboard bench for ad9252_fco_align
`timescale 1ns/1ps
module tb_ad9252_fco_align;

    localparam logic [13:0] PAT = 14'h3F80;
    localparam int EV_SLIP  = 100000;
    localparam int EV_ALIGN = 200000;
    localparam int EV_FAIL  = 300000;
    localparam int EV_CE    = 500000;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        align_start;
    logic        corrupt;
    logic [13:0] word;
    logic [13:0] fco_word;
    logic        bit_slip;
    logic        aligned;
    logic        align_fail;
    logic        lock_lost;
    logic [3:0]  slip_cnt;
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
    logic        delay_ce;
    logic        delay_inc;
    logic [4:0]  tap_cnt;
`endif

    int   cyc;
    int   n_checks;
    int   n_fail;
    int   found;
    int   cur;
    logic prev_al;
    logic prev_af;
    int   exp_q[$];

    always #5 clk = ~clk;

    assign fco_word = corrupt ? ~word : word;

    ad9252_fco_align dut (
        .ad_dco_fc   (clk),
        .reset       (rst),
        .clk_en      (clk_en),
        .align_start (align_start),
        .fco_pattern (fco_word),
        .bit_slip    (bit_slip),
        .aligned     (aligned),
        .align_fail  (align_fail),
        .lock_lost   (lock_lost),
        .slip_cnt    (slip_cnt)
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
        ,
        .delay_ce    (delay_ce),
        .delay_inc   (delay_inc),
        .tap_cnt     (tap_cnt)
`endif
    );

    function automatic logic [13:0] rotl(input logic [13:0] w);
        return {w[12:0], w[13]};
    endfunction

    function automatic logic [13:0] rotr(input logic [13:0] w, input int n);
        logic [13:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[0], r[13:1]};
        return r;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic report_event(input int ev);
        int e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_event", ev, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("event", ev, e);
        end
    endtask

    // One clock: model the cycle count at the edge, observe the DUT at the falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst) cyc = 0;
            else if (align_start && clk_en) cyc = 0;
            else cyc++;
            @(negedge clk);
            if (!rst) begin
                if (bit_slip) begin
                    report_event(EV_SLIP + cyc);
                    word = rotl(word);
                end
                if (aligned && !prev_al) report_event(EV_ALIGN + cyc);
                if (align_fail && !prev_af) report_event(EV_FAIL + cyc);
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
                if (delay_ce) begin
                    report_event(EV_CE + cyc);
                    check_eq("delay_inc", int'(delay_inc), 1);
                end
`endif
            end
            prev_al = aligned;
            prev_af = align_fail;
        end
    endtask

    task automatic do_reset(input logic [13:0] w);
        rst = 1'b1;
        clk_en = 1'b1;
        align_start = 1'b0;
        corrupt = 1'b0;
        word = w;
        exp_q.delete();
        tick(2);
        check_eq("rst_outputs", int'({bit_slip, aligned, align_fail, lock_lost, slip_cnt}), 0);
`ifdef AD9252_FCO_ALIGN_IDELAY_EN
        check_eq("rst_idelay", int'({delay_ce, delay_inc, tap_cnt}), 0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        prev_al = 1'b0;
        prev_af = 1'b0;
        rst = 1'b0;
        clk_en = 1'b1;
        align_start = 1'b0;
        corrupt = 1'b0;
        word = PAT;

        // Already aligned
        do_reset(PAT);
        exp_q.push_back(EV_ALIGN + 12);
        tick(20);
        check_eq("aligned_lock", int'(aligned), 1);
        check_eq("aligned_slips", int'(slip_cnt), 0);
        check_eq("aligned_q", exp_q.size(), 0);

        // Rotated by three
        do_reset(rotr(PAT, 3));
        for (int i = 0; i < 3; i++) exp_q.push_back(EV_SLIP + 5 + 6 * i);
        exp_q.push_back(EV_ALIGN + 30);
        tick(40);
        check_eq("rot3_lock", int'(aligned), 1);
        check_eq("rot3_slips", int'(slip_cnt), 3);
        check_eq("rot3_q", exp_q.size(), 0);

`ifndef AD9252_FCO_ALIGN_IDELAY_EN
        // Never-matching word
        do_reset(14'h0000);
        for (int i = 0; i < 14; i++) exp_q.push_back(EV_SLIP + 5 + 6 * i);
        exp_q.push_back(EV_FAIL + 89);
        tick(95);
        check_eq("fail_flag", int'(align_fail), 1);
        check_eq("fail_aligned", int'(aligned), 0);
        check_eq("fail_slips", int'(slip_cnt), 14);
        check_eq("fail_q", exp_q.size(), 0);
        word = PAT;
        exp_q.push_back(EV_ALIGN + 12);
        align_start = 1'b1;
        tick(1);
        align_start = 1'b0;
        check_eq("restart_slips", int'(slip_cnt), 0);
        check_eq("restart_fail", int'(align_fail), 0);
        tick(13);
        check_eq("restart_lock", int'(aligned), 1);
        check_eq("restart_q", exp_q.size(), 0);
`else
        // Never-matching word with delay-line stepping
        do_reset(14'h0000);
        for (int t = 0; t < 32; t++) begin
            for (int i = 0; i < 14; i++) exp_q.push_back(EV_SLIP + t * 89 + 5 + 6 * i);
            if (t < 31) exp_q.push_back(EV_CE + (t + 1) * 89);
        end
        exp_q.push_back(EV_FAIL + 32 * 89);
        exp_q.push_back(EV_CE + 32 * 89);
        tick(32 * 89 + 6);
        check_eq("idly_fail", int'(align_fail), 1);
        check_eq("idly_tap_wrap", int'(tap_cnt), 0);
        check_eq("idly_q", exp_q.size(), 0);
`endif

        // Lock loss tolerance and detection
        do_reset(PAT);
        exp_q.push_back(EV_ALIGN + 12);
        tick(14);
        corrupt = 1'b1;
        tick(3);
        corrupt = 1'b0;
        tick(4);
        check_eq("miss3_lock", int'(aligned), 1);
        check_eq("miss3_lost", int'(lock_lost), 0);
        cur = cyc;
        exp_q.push_back(EV_ALIGN + cur + 16);
        corrupt = 1'b1;
        tick(4);
        check_eq("miss4_aligned", int'(aligned), 0);
        check_eq("miss4_lost", int'(lock_lost), 1);
        corrupt = 1'b0;
        tick(14);
        check_eq("relock", int'(aligned), 1);
        check_eq("lost_sticky", int'(lock_lost), 1);
        exp_q.push_back(EV_ALIGN + 12);
        align_start = 1'b1;
        tick(1);
        align_start = 1'b0;
        check_eq("start_clr_lost", int'(lock_lost), 0);
        check_eq("start_drop_align", int'(aligned), 0);
        tick(13);
        check_eq("loss_q", exp_q.size(), 0);

        // clk_en low for ten cycles mid-SETTLE; align_start inside the hold is ignored
        do_reset(PAT);
        exp_q.push_back(EV_ALIGN + 22);
        tick(2);
        clk_en = 1'b0;
        align_start = 1'b1;
        tick(1);
        align_start = 1'b0;
        tick(9);
        check_eq("hold_aligned", int'(aligned), 0);
        check_eq("hold_slips", int'(slip_cnt), 0);
        clk_en = 1'b1;
        tick(12);
        check_eq("hold_lock", int'(aligned), 1);
        check_eq("hold_q", exp_q.size(), 0);

        // Reset asserted during the SLIP cycle
        do_reset(rotr(PAT, 1));
        exp_q.push_back(EV_SLIP + 5);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick(1);
            if (bit_slip) found = 1;
        end
        check_eq("slip_seen", found, 1);
        #1 rst = 1'b1;
        #1 check_eq("async_rst_slip", int'(bit_slip), 0);
        tick(2);
        rst = 1'b0;
        exp_q.push_back(EV_ALIGN + 12);
        tick(14);
        check_eq("post_rst_lock", int'(aligned), 1);
        check_eq("post_rst_q", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
